id_ex_elastic_stage: RTL and testbench



---
 rtl/id_ex_elastic_stage.sv | 239 +++++++++++++++++++++++
 tb/tb_id_ex_elastic_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_elastic_stage.sv
// id_ex_elastic_stage
// Elastic ID/EX pipeline stage: carries one decoded instruction (control word,
// NUM_SRC operands with their source addresses, destination and immediate)
// from decode to execute through a valid/ready handshake backed by a main
// (head) entry and a skid entry. in_ready_o is a flop, so an execute stall
// never reaches decode combinationally. flush_i empties the stage.
//
// Optional feature: define ID_EX_WB_BYPASS_EN to let a same-edge register-file
// write-back replace matching operands in captured or held entries. Without
// it operands are stored verbatim and the wb_* ports are ignored.

module id_ex_elastic_stage #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int CTRL_W  = 8,
    parameter int NUM_SRC = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      flush_i,

    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [CTRL_W-1:0]         in_ctrl_i,
    input  logic [NUM_SRC*DATA_W-1:0] in_data_i,
    input  logic [NUM_SRC*ADDR_W-1:0] in_src_addr_i,
    input  logic [ADDR_W-1:0]         in_dst_addr_i,
    input  logic [DATA_W-1:0]         in_imm_i,

    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [CTRL_W-1:0]         out_ctrl_o,
    output logic [NUM_SRC*DATA_W-1:0] out_data_o,
    output logic [NUM_SRC*ADDR_W-1:0] out_src_addr_o,
    output logic [ADDR_W-1:0]         out_dst_addr_o,
    output logic [DATA_W-1:0]         out_imm_o,

    input  logic                      wb_en_i,
    input  logic [ADDR_W-1:0]         wb_addr_i,
    input  logic [DATA_W-1:0]         wb_data_i,

    output logic [1:0]                occupancy_o
);

    localparam int OPS_W  = NUM_SRC * DATA_W;
    localparam int SRCS_W = NUM_SRC * ADDR_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic              in_ready_q;

    logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
    logic [OPS_W-1:0]  main_data_q, skid_data_q;
    logic [SRCS_W-1:0] main_src_q,  skid_src_q;
    logic [ADDR_W-1:0] main_dst_q,  skid_dst_q;
    logic [DATA_W-1:0] main_imm_q,  skid_imm_q;

    logic              main_valid, skid_valid;
    logic              push, pop;
    logic              main_load_in, main_load_skid, skid_load;

    logic [CTRL_W-1:0] main_ctrl_d, skid_ctrl_d;
    logic [OPS_W-1:0]  main_data_sel, skid_data_sel;
    logic [OPS_W-1:0]  main_data_d, skid_data_d;
    logic [SRCS_W-1:0] main_src_d,  skid_src_d;
    logic [ADDR_W-1:0] main_dst_d,  skid_dst_d;
    logic [DATA_W-1:0] main_imm_d,  skid_imm_d;

    assign main_valid = (state_q != ST_EMPTY);
    assign skid_valid = (state_q == ST_FULL);

    assign push = in_valid_i & in_ready_q;
    assign pop  = main_valid & out_ready_i;

    // Next-state and entry-load decisions; flush overrides every transfer.
    always_comb begin
        state_d        = state_q;
        main_load_in   = 1'b0;
        main_load_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_d      = ST_ONE;
                        main_load_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (push && !pop) begin
                        state_d   = ST_FULL;
                        skid_load = 1'b1;
                    end else if (!push && pop) begin
                        state_d = ST_EMPTY;
                    end else if (push && pop) begin
                        state_d      = ST_ONE;
                        main_load_in = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_d        = ST_ONE;
                        main_load_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Select what each entry holds after this edge before any write-back patch.
    always_comb begin
        main_ctrl_d   = main_ctrl_q;
        main_data_sel = main_data_q;
        main_src_d    = main_src_q;
        main_dst_d    = main_dst_q;
        main_imm_d    = main_imm_q;
        if (main_load_in) begin
            main_ctrl_d   = in_ctrl_i;
            main_data_sel = in_data_i;
            main_src_d    = in_src_addr_i;
            main_dst_d    = in_dst_addr_i;
            main_imm_d    = in_imm_i;
        end else if (main_load_skid) begin
            main_ctrl_d   = skid_ctrl_q;
            main_data_sel = skid_data_q;
            main_src_d    = skid_src_q;
            main_dst_d    = skid_dst_q;
            main_imm_d    = skid_imm_q;
        end

        skid_ctrl_d   = skid_ctrl_q;
        skid_data_sel = skid_data_q;
        skid_src_d    = skid_src_q;
        skid_dst_d    = skid_dst_q;
        skid_imm_d    = skid_imm_q;
        if (skid_load) begin
            skid_ctrl_d   = in_ctrl_i;
            skid_data_sel = in_data_i;
            skid_src_d    = in_src_addr_i;
            skid_dst_d    = in_dst_addr_i;
            skid_imm_d    = in_imm_i;
        end
    end

`ifdef ID_EX_WB_BYPASS_EN
    // Replace every operand whose source register is being written this edge;
    // register 0 is hard-wired and never forwarded.
    function automatic logic [OPS_W-1:0] apply_wb(input logic [OPS_W-1:0]  ops,
                                                  input logic [SRCS_W-1:0] srcs);
        logic [OPS_W-1:0] res;
        res = ops;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (wb_en_i && (wb_addr_i != '0) &&
                (wb_addr_i == srcs[k*ADDR_W +: ADDR_W])) begin
                res[k*DATA_W +: DATA_W] = wb_data_i;
            end
        end
        return res;
    endfunction

    // Patch the selected operands with the concurrent write-back.
    always_comb begin
        main_data_d = apply_wb(main_data_sel, main_src_d);
        skid_data_d = apply_wb(skid_data_sel, skid_src_d);
    end
`else
    logic unused_wb;
    assign unused_wb = ^{wb_en_i, wb_addr_i, wb_data_i};

    // Operands pass through untouched when forwarding is compiled out.
    always_comb begin
        main_data_d = main_data_sel;
        skid_data_d = skid_data_sel;
    end
`endif

    // Control state and the registered ready flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    // Entry payload storage; cleared on reset so a fresh stage shows zeros.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            main_ctrl_q <= '0;
            main_data_q <= '0;
            main_src_q  <= '0;
            main_dst_q  <= '0;
            main_imm_q  <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_src_q  <= '0;
            skid_dst_q  <= '0;
            skid_imm_q  <= '0;
        end else begin
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            main_src_q  <= main_src_d;
            main_dst_q  <= main_dst_d;
            main_imm_q  <= main_imm_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_src_q  <= skid_src_d;
            skid_dst_q  <= skid_dst_d;
            skid_imm_q  <= skid_imm_d;
        end
    end

    // Occupancy follows directly from the registered state.
    always_comb begin
        occupancy_o = 2'd0;
        if (skid_valid)      occupancy_o = 2'd2;
        else if (main_valid) occupancy_o = 2'd1;
    end

    assign in_ready_o     = in_ready_q;
    assign out_valid_o    = main_valid;
    assign out_ctrl_o     = main_valid ? main_ctrl_q : '0;
    assign out_data_o     = main_data_q;
    assign out_src_addr_o = main_src_q;
    assign out_dst_addr_o = main_dst_q;
    assign out_imm_o      = main_imm_q;

endmodule

// File: tb/tb_id_ex_elastic_stage.sv
// tb_id_ex_elastic_stage
// Directed self-checking bench for id_ex_elastic_stage: reset, streaming,
// stall/skid, flush and write-back bypass (expectation follows whether
// ID_EX_WB_BYPASS_EN is defined for this build).

module tb_id_ex_elastic_stage;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int CTRL_W  = 8;
    localparam int NUM_SRC = 2;

    logic                      clk_i;
    logic                      rst_n_i;
    logic                      flush_i;
    logic                      in_valid_i;
    logic                      in_ready_o;
    logic [CTRL_W-1:0]         in_ctrl_i;
    logic [NUM_SRC*DATA_W-1:0] in_data_i;
    logic [NUM_SRC*ADDR_W-1:0] in_src_addr_i;
    logic [ADDR_W-1:0]         in_dst_addr_i;
    logic [DATA_W-1:0]         in_imm_i;
    logic                      out_valid_o;
    logic                      out_ready_i;
    logic [CTRL_W-1:0]         out_ctrl_o;
    logic [NUM_SRC*DATA_W-1:0] out_data_o;
    logic [NUM_SRC*ADDR_W-1:0] out_src_addr_o;
    logic [ADDR_W-1:0]         out_dst_addr_o;
    logic [DATA_W-1:0]         out_imm_o;
    logic                      wb_en_i;
    logic [ADDR_W-1:0]         wb_addr_i;
    logic [DATA_W-1:0]         wb_data_i;
    logic [1:0]                occupancy_o;

    int total = 0;
    int bad   = 0;

    id_ex_elastic_stage #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W), .NUM_SRC(NUM_SRC)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_ctrl_i(in_ctrl_i), .in_data_i(in_data_i),
        .in_src_addr_i(in_src_addr_i), .in_dst_addr_i(in_dst_addr_i),
        .in_imm_i(in_imm_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_ctrl_o(out_ctrl_o), .out_data_o(out_data_o),
        .out_src_addr_o(out_src_addr_o), .out_dst_addr_o(out_dst_addr_o),
        .out_imm_o(out_imm_o),
        .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .occupancy_o(occupancy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance to 1 time unit past the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Present an instruction whose fields are all derived from its control word.
    task automatic set_in(input logic v, input logic [7:0] c);
        in_valid_i    = v;
        in_ctrl_i     = c;
        in_data_i     = {32'h0000_0200 + {24'h0, c}, 32'h0000_0100 + {24'h0, c}};
        in_src_addr_i = {5'd2, 5'd1};
        in_dst_addr_i = c[4:0];
        in_imm_i      = 32'hFFFF_FF00 | {24'h0, c};
    endtask

    task automatic test_reset();
        // Reset held across the first edge, sampled before release.
        #12;
        total++; if (in_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL rst_ready got=%0b want=1", in_ready_o); end
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid got=%0b want=0", out_valid_o); end
        total++; if (occupancy_o !== 2'd0) begin bad++; $display("[TB] FAIL rst_occ got=%0d want=0", occupancy_o); end
        total++; if (out_data_o !== 64'h0 || out_imm_o !== 32'h0) begin bad++; $display("[TB] FAIL rst_fields got=%h/%h want=0", out_data_o, out_imm_o); end
        rst_n_i = 1'b1;
        step();
        // Load one instruction then pull reset in the middle of the cycle.
        set_in(1'b1, 8'h55);
        step();
        set_in(1'b0, 8'h00);
        total++; if (out_valid_o !== 1'b1 || out_ctrl_o !== 8'h55) begin bad++; $display("[TB] FAIL pre_rst_head got=%0b/%h want=1/55", out_valid_o, out_ctrl_o); end
        #2 rst_n_i = 1'b0;
        #1;
        total++; if (out_valid_o !== 1'b0 || out_ctrl_o !== 8'h00) begin bad++; $display("[TB] FAIL async_rst_out got=%0b/%h want=0/00", out_valid_o, out_ctrl_o); end
        total++; if (in_ready_o !== 1'b1 || occupancy_o !== 2'd0) begin bad++; $display("[TB] FAIL async_rst_ctl got=%0b/%0d want=1/0", in_ready_o, occupancy_o); end
        total++; if (out_data_o !== 64'h0) begin bad++; $display("[TB] FAIL async_rst_data got=%h want=0", out_data_o); end
        #2 rst_n_i = 1'b1;
        step();
    endtask

    task automatic test_stream();
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 8'h11 + 8'(i));
            step();
            total++; if (out_valid_o !== 1'b1 || out_ctrl_o !== 8'h11 + 8'(i)) begin bad++; $display("[TB] FAIL stream_head%0d got=%0b/%h want=1/%h", i, out_valid_o, out_ctrl_o, 8'h11 + 8'(i)); end
            total++; if (out_data_o[31:0] !== 32'h0000_0111 + i || out_data_o[63:32] !== 32'h0000_0211 + i) begin bad++; $display("[TB] FAIL stream_data%0d got=%h", i, out_data_o); end
            total++; if (occupancy_o !== 2'd1 || in_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL stream_ctl%0d got=%0d/%0b want=1/1", i, occupancy_o, in_ready_o); end
        end
        total++; if (out_imm_o !== 32'hFFFF_FF14 || out_dst_addr_o !== 5'h14) begin bad++; $display("[TB] FAIL stream_imm_dst got=%h/%h want=ffffff14/14", out_imm_o, out_dst_addr_o); end
        set_in(1'b0, 8'h00);
        step();
        total++; if (out_valid_o !== 1'b0 || out_ctrl_o !== 8'h00 || occupancy_o !== 2'd0) begin bad++; $display("[TB] FAIL stream_drain got=%0b/%h/%0d want=0/00/0", out_valid_o, out_ctrl_o, occupancy_o); end
    endtask

    task automatic test_stall();
        out_ready_i = 1'b0;
        set_in(1'b1, 8'hA1);
        step();
        total++; if (out_ctrl_o !== 8'hA1 || occupancy_o !== 2'd1 || in_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL stall_a got=%h/%0d/%0b want=a1/1/1", out_ctrl_o, occupancy_o, in_ready_o); end
        set_in(1'b1, 8'hB2);
        step();
        total++; if (out_ctrl_o !== 8'hA1 || occupancy_o !== 2'd2 || in_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL stall_full got=%h/%0d/%0b want=a1/2/0", out_ctrl_o, occupancy_o, in_ready_o); end
        set_in(1'b1, 8'hC3);
        step();
        total++; if (out_ctrl_o !== 8'hA1 || occupancy_o !== 2'd2 || in_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL stall_hold got=%h/%0d/%0b want=a1/2/0", out_ctrl_o, occupancy_o, in_ready_o); end
        out_ready_i = 1'b1;
        step();
        total++; if (out_ctrl_o !== 8'hB2 || out_data_o[31:0] !== 32'h0000_01B2 || occupancy_o !== 2'd1 || in_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL stall_b got=%h/%h/%0d/%0b want=b2/1b2/1/1", out_ctrl_o, out_data_o[31:0], occupancy_o, in_ready_o); end
        step();
        set_in(1'b0, 8'h00);
        total++; if (out_valid_o !== 1'b1 || out_ctrl_o !== 8'hC3 || occupancy_o !== 2'd1) begin bad++; $display("[TB] FAIL stall_c got=%0b/%h/%0d want=1/c3/1", out_valid_o, out_ctrl_o, occupancy_o); end
        step();
        total++; if (out_valid_o !== 1'b0 || occupancy_o !== 2'd0) begin bad++; $display("[TB] FAIL stall_drain got=%0b/%0d want=0/0", out_valid_o, occupancy_o); end
    endtask

    task automatic test_flush();
        // Flush from FULL with an instruction on the input.
        out_ready_i = 1'b0;
        set_in(1'b1, 8'hA4);
        step();
        set_in(1'b1, 8'hB5);
        step();
        set_in(1'b1, 8'hC6);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        set_in(1'b0, 8'h00);
        total++; if (occupancy_o !== 2'd0 || out_valid_o !== 1'b0 || out_ctrl_o !== 8'h00 || in_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL flush_full got=%0d/%0b/%h/%0b want=0/0/00/1", occupancy_o, out_valid_o, out_ctrl_o, in_ready_o); end
        // Flush from ONE while an accepted push is offered: it must be dropped.
        set_in(1'b1, 8'hD7);
        step();
        set_in(1'b1, 8'hE8);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        set_in(1'b0, 8'h00);
        out_ready_i = 1'b1;
        total++; if (occupancy_o !== 2'd0 || out_valid_o !== 1'b0 || out_ctrl_o !== 8'h00) begin bad++; $display("[TB] FAIL flush_drop got=%0d/%0b/%h want=0/0/00", occupancy_o, out_valid_o, out_ctrl_o); end
        step();
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL flush_ghost got=%0b want=0", out_valid_o); end
    endtask

    task automatic test_bypass();
        logic [31:0] want;
`ifdef ID_EX_WB_BYPASS_EN
        want = 32'h0000_DEAD;
`else
        want = 32'h0000_0001;
`endif
        out_ready_i   = 1'b0;
        in_valid_i    = 1'b1;
        in_ctrl_i     = 8'h3C;
        in_data_i     = {32'h0000_0002, 32'h0000_0001};
        in_src_addr_i = {5'd6, 5'd5};
        in_dst_addr_i = 5'd7;
        in_imm_i      = 32'h0;
        step();
        in_valid_i = 1'b0;
        wb_en_i    = 1'b1;
        wb_addr_i  = 5'd5;
        wb_data_i  = 32'h0000_DEAD;
        step();
        wb_en_i = 1'b0;
        total++; if (out_data_o[31:0] !== want) begin bad++; $display("[TB] FAIL bypass_hit got=%h want=%h", out_data_o[31:0], want); end
        total++; if (out_data_o[63:32] !== 32'h0000_0002) begin bad++; $display("[TB] FAIL bypass_other got=%h want=2", out_data_o[63:32]); end
        // Drain, then repeat with a write to register 0.
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        step();
        in_valid_i = 1'b0;
        wb_en_i    = 1'b1;
        wb_addr_i  = 5'd0;
        wb_data_i  = 32'h0000_DEAD;
        step();
        wb_en_i = 1'b0;
        total++; if (out_data_o[31:0] !== 32'h0000_0001 || out_ctrl_o !== 8'h3C) begin bad++; $display("[TB] FAIL bypass_r0 got=%h/%h want=1/3c", out_data_o[31:0], out_ctrl_o); end
        out_ready_i = 1'b1;
        step();
    endtask

    initial begin
        rst_n_i     = 1'b0;
        flush_i     = 1'b0;
        out_ready_i = 1'b0;
        wb_en_i     = 1'b0;
        wb_addr_i   = '0;
        wb_data_i   = '0;
        set_in(1'b0, 8'h00);
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_bypass();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
